// File: rtl/pc_seq_if.sv
// Request/response bundle between the fetch-stage controller and the pc_seq
// program-counter sequencer.
interface pc_seq_if #(
    parameter int BITS = 8
);
    logic            stall;
    logic            brzr_sel;
    logic            jmp_sel;
    logic            call_sel;
    logic            ret_sel;
    logic [BITS-1:0] pc_brzr;
    logic [BITS-1:0] pc_jmp;
    logic [BITS-1:0] pc;
    logic [BITS-1:0] next_pc;
    logic            ras_empty;
    logic            ras_full;
    logic            sel_err;
    logic            ras_ovf;
    logic            ras_unf;

    modport master (
        output stall, brzr_sel, jmp_sel, call_sel, ret_sel, pc_brzr, pc_jmp,
        input  pc, next_pc, ras_empty, ras_full, sel_err, ras_ovf, ras_unf
    );

    modport slave (
        input  stall, brzr_sel, jmp_sel, call_sel, ret_sel, pc_brzr, pc_jmp,
        output pc, next_pc, ras_empty, ras_full, sel_err, ras_ovf, ras_unf
    );
endinterface

// File: rtl/pc_seq.sv
// Program-counter sequencer with stall, return-address stack and error pulses.
// Define NEXT_PC_TRAP_EN to redirect every erroneous request to TRAP_PC.
module pc_seq #(
    parameter int BITS      = 8,
    parameter int RESET_PC  = 0,
    parameter int STEP      = 1,
    parameter int RAS_DEPTH = 4,
    parameter int TRAP_PC   = 0
) (
    input  logic    clk,
    input  logic    rst,
    pc_seq_if.slave bus
);
    localparam int AW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);
`ifdef NEXT_PC_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    localparam logic [BITS-1:0] TRAP_VEC = BITS'(TRAP_PC);
    localparam logic [BITS-1:0] RST_VEC  = BITS'(RESET_PC);
    localparam logic [BITS-1:0] STEP_VEC = BITS'(STEP);

    logic [BITS-1:0] pc_q;
    logic [BITS-1:0] ras_mem [RAS_DEPTH];
    logic [AW-1:0]   sp_q;      // next free slot; sp_q-1 is the top entry
    logic [CW-1:0]   count_q;
    logic            sel_err_q;
    logic            ovf_q;
    logic            unf_q;

    logic [BITS-1:0] seq;
    logic [BITS-1:0] top;
    logic [BITS-1:0] next;
    logic            full;
    logic            empty;
    logic            multi;
    logic            sel_err_d;
    logic            ovf_d;
    logic            unf_d;
    logic            trap;
    logic            push;
    logic            pop;

    assign full  = (count_q == CW'(RAS_DEPTH));
    assign empty = (count_q == '0);
    assign top   = ras_mem[sp_q - AW'(1)];

    always_comb begin
        seq   = pc_q + STEP_VEC;
        multi = (bus.brzr_sel & bus.jmp_sel)  | (bus.brzr_sel & bus.call_sel) |
                (bus.brzr_sel & bus.ret_sel)  | (bus.jmp_sel  & bus.call_sel) |
                (bus.jmp_sel  & bus.ret_sel)  | (bus.call_sel & bus.ret_sel);
        sel_err_d = !bus.stall && multi;
        ovf_d     = !bus.stall && !multi && bus.call_sel && full;
        unf_d     = !bus.stall && !multi && bus.ret_sel && empty;
        trap      = TRAP_EN && (sel_err_d || ovf_d || unf_d);
        // With trapping enabled an overflowing call is abandoned, so it does not push.
        push      = !bus.stall && !multi && bus.call_sel && !(full && TRAP_EN);
        pop       = !bus.stall && !multi && bus.ret_sel && !empty;

        next = seq;
        if (bus.stall)         next = pc_q;
        else if (trap)         next = TRAP_VEC;
        else if (multi)        next = seq;
        else if (bus.brzr_sel) next = bus.pc_brzr;
        else if (bus.jmp_sel)  next = bus.pc_jmp;
        else if (bus.call_sel) next = bus.pc_jmp;
        else if (bus.ret_sel)  next = empty ? seq : top;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RST_VEC;
            sp_q      <= '0;
            count_q   <= '0;
            sel_err_q <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            pc_q      <= next;
            sel_err_q <= sel_err_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            if (push) begin
                sp_q <= sp_q + AW'(1);
                if (!full) count_q <= count_q + CW'(1);
            end else if (pop) begin
                sp_q    <= sp_q - AW'(1);
                count_q <= count_q - CW'(1);
            end
        end
    end

    // When full, sp_q already points at the oldest entry, so a push overwrites it.
    always_ff @(posedge clk) begin
        if (!rst && push) ras_mem[sp_q] <= seq;
    end

    assign bus.pc        = pc_q;
    assign bus.next_pc   = next;
    assign bus.ras_empty = empty;
    assign bus.ras_full  = full;
    assign bus.sel_err   = sel_err_q;
    assign bus.ras_ovf   = ovf_q;
    assign bus.ras_unf   = unf_q;
endmodule

// File: doc/pc_seq.md
Name: pc_seq

Overview:
Parametrised program-counter sequencer, the successor to the combinational next-PC selector in the fetch stage.
- Holds the architectural PC register and computes the next PC from branch-if-zero, jump, call and return requests.
- Adds a stall hold, a configurable return-address stack (RAS), and error reporting for illegal select combinations and stack misuse.
- Feeds the instruction-memory address each cycle.

Parameters:
BITS, 8, PC and target width in bits.
RESET_PC, 0, PC value loaded on reset.
STEP, 1, sequential increment added to PC each non-redirected cycle.
RAS_DEPTH, 4, return-address stack entries; power of two, >=2.
TRAP_PC, 0, trap vector; used only when NEXT_PC_TRAP_EN is defined.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
stall  input  1  hold PC and RAS this cycle.
brzr_sel  input  1  take branch-if-zero target.
jmp_sel  input  1  take jump target.
call_sel  input  1  push return address, go to pc_jmp.
ret_sel  input  1  pop return address, go to it.
pc_brzr  input  BITS  branch target.
pc_jmp  input  BITS  jump/call target.
pc  output  BITS  registered current PC.
next_pc  output  BITS  combinational value pc will take at the next edge.
ras_empty  output  1  RAS holds 0 entries.
ras_full  output  1  RAS holds RAS_DEPTH entries.
sel_err  output  1  registered one-cycle pulse: more than one select was high.
ras_ovf  output  1  registered one-cycle pulse: call while full.
ras_unf  output  1  registered one-cycle pulse: ret while empty.

Behaviour:
- Reset (rst=1 at edge) overrides everything.
  - pc=RESET_PC; RAS count=0, so ras_empty=1 and ras_full=0.
  - sel_err, ras_ovf and ras_unf all 0.
  - Reset mid-sequence discards all RAS contents.
- stall=1 (no rst):
  - pc, RAS and count hold; next_pc=pc.
  - All selects ignored; error pulses are 0 on the following cycle.
- Selects are sampled at the edge; the new pc is visible one cycle after the request (1-cycle latency).
- seq = (pc+STEP) mod 2^BITS; wraps, e.g. BITS=8: 0xFF+1 -> 0x00.
- Exactly one select high:
  - brzr_sel: pc<=pc_brzr.
  - jmp_sel: pc<=pc_jmp.
  - call_sel: push seq; pc<=pc_jmp.
  - ret_sel: pop top entry; pc<=popped value.
- No select high: pc<=seq.
- Two or more selects high: illegal.
  - pc<=seq; RAS unchanged; sel_err=1 next cycle.
  - This includes brzr_sel+jmp_sel together.
- RAS is LIFO with a circular top index.
  - Call when full: overwrite the oldest entry (the index wraps), count stays RAS_DEPTH, ras_ovf=1 next cycle, pc<=pc_jmp.
  - Ret when empty: pc<=seq, count stays 0, ras_unf=1 next cycle.
  - Count tracks 0..RAS_DEPTH; ras_full/ras_empty are derived from the registered count.
- Error pulses last exactly one cycle per offending edge; back-to-back offences give back-to-back pulses.
- next_pc is purely combinational from the current pc, selects, stall and RAS top. rst does not affect next_pc combinationally.

Optional Feature:
Macro NEXT_PC_TRAP_EN.
- Defined: any condition that raises sel_err, ras_ovf or ras_unf instead sets pc<=TRAP_PC.
  - A call while full does not push.
  - The pulses still fire.
  - next_pc reflects TRAP_PC in the same cycle.
- Undefined: behaviour exactly as described in Behaviour; the TRAP_PC parameter is unused.

Test Plan:
1. Reset, then idle 3 cycles (BITS=8, STEP=1, RESET_PC=0x10) -> pc 0x10,0x11,0x12,0x13; ras_empty=1.
2. pc=0xFF, no select -> pc=0x00. stall=1 for 2 cycles at pc=0x05 -> pc stays 0x05; then releases to 0x06.
3. At pc=0x20, call to 0x40, idle 2 cycles, ret -> pc 0x40,0x41,0x42, then 0x21; ras_empty=1 after the ret.
4. 5 nested calls (RAS_DEPTH=4) -> 5th gives ras_ovf pulse and ras_full=1. 4 rets return the 4 newest addresses; a 5th ret gives ras_unf pulse and pc=seq.
5. brzr_sel=jmp_sel=1 at pc=0x30 -> pc=0x31, sel_err high for 1 cycle, RAS untouched. With NEXT_PC_TRAP_EN and TRAP_PC=0xF0 -> pc=0xF0.
6. rst asserted mid-call chain (count=3) -> next cycle pc=RESET_PC, ras_empty=1, all error pulses 0.
